sfifo_if_ntuner: RTL and testbench
==================================

SFIFO_IF_NTUNER -- requirements
Module: sfifo_if_ntuner

Interface
REQ-001 SHALL have parameter NCH, default 3, giving the number of tuner channels (1..8).
REQ-002 SHALL have parameter PKT_LEN, default 188, giving the bytes per packet (188 or 204, never more than 256).
REQ-003 SHALL have parameter FIFO_ADDR, default 2'b01, giving the constant value driven on fadd.
REQ-004 SHALL provide the following ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- flaga  in  1  USB FIFO empty flag, active-low; unused internally.
- flagb  in  1  USB FIFO full flag, active-low.
- fadd  out  2  FIFO address; constant FIFO_ADDR.
- sloe, slrd  out  1 each  constant 1.
- slwr  out  1  write strobe, active-low.
- data_out  out  8  write data.
- pktstart_o, pktend_o  out  1 each  packet boundary strobes, active-low.
- pid_idx  out  12  PID of the current packet.
- mrxdv  out  1  high while a packet is in transfer.
- pkt_rdy  in  NCH  per channel, level: a full packet is buffered.
- pkt_half  in  NCH  per channel: which buffer half holds that packet.
- pkt_pid  in  12*NCH  per-channel PID; channel i uses bits [12i+11:12i].
- pkt_ack  out  NCH  one-cycle pulse per channel: packet consumed.
- db_radd_en  out  1  buffer read enable.
- db_radd  out  9  buffer read address: {half, byte offset}.
- db_rdata  in  8*NCH  per-channel buffer read data; 1-cycle registered read latency.

Function
REQ-005 SHALL implement a state machine with states IDLE, XFER, DRAIN and END.
REQ-006 In IDLE, when any pkt_rdy bit is high, SHALL grant by round-robin starting at (last grant + 1) mod NCH, then go to XFER in the next cycle.
REQ-007 At grant SHALL latch the channel number, pkt_half[ch] and pkt_pid[ch]; pid_idx SHALL update in the grant cycle.
REQ-008 In XFER, SHALL assert db_radd_en = flagb and drive db_radd = {half, offset}; offset SHALL increment only when flagb is high.
REQ-009 The stage-1 valid bit SHALL follow the accepted read with 1-cycle latency; data_out SHALL be db_rdata of the granted channel; slwr SHALL equal ~(stage-1 valid & flagb).
REQ-010 When flagb is low with stage-1 valid, SHALL hold the address, stage-1 valid and the memory output (db_radd_en low); no byte SHALL be lost or duplicated.
REQ-011 After offset PKT_LEN-1 is issued, SHALL enter DRAIN and wait until the last byte is written.
REQ-012 pktstart_o SHALL be low for exactly the cycle in which byte 0 is written.
REQ-013 In END (one cycle), SHALL pulse pktend_o low and pulse pkt_ack[ch], then return to IDLE.
REQ-014 mrxdv SHALL be high in XFER, DRAIN and END.
REQ-015 A channel with pkt_rdy still high after its ack SHALL become eligible again only after the other ready channels are served.
REQ-016 Request changes during XFER, DRAIN or END SHALL NOT affect the current packet.
REQ-017 With NCH=1, arbitration SHALL degenerate to always granting channel 0.

Reset
REQ-018 While rst is low, outputs SHALL be: slwr=1, pktstart_o=1, pktend_o=1, pkt_ack=0, db_radd_en=0, db_radd=0, pid_idx=0, mrxdv=0, data_out=0, state=IDLE, and the last grant SHALL be NCH-1.
REQ-019 A reset asserted mid-packet SHALL discard the partial packet: no pktend_o and no pkt_ack.

Configuration
REQ-020 With macro SFIFO_CHTAG_EN defined, byte 0 of each packet SHALL be replaced on data_out by 8'hB0 + channel number.
REQ-021 Without SFIFO_CHTAG_EN, byte 0 SHALL pass through unchanged (normally 8'h47).

Verification
REQ-022 NCH=3, flagb high, pkt_rdy=3'b001, pid 0x100 -> 188 consecutive slwr lows, pktstart_o low on byte 0, pktend_o low one cycle later, pkt_ack=001, pid_idx=0x100.
REQ-023 pkt_rdy=3'b111 held -> packets granted in channel order 0,1,2,0,...
REQ-024 flagb forced low for 5 cycles at byte 100 -> slwr high for those cycles, bytes 100..187 each written exactly once, in order.
REQ-025 rst driven low at byte 50 -> all outputs at reset values next cycle, no ack; after release the next grant is channel 0.
REQ-026 SFIFO_CHTAG_EN defined, channel 2 packet -> first byte 8'hB2; macro undefined -> 8'h47.
REQ-027 PKT_LEN=204, pkt_half=1 -> db_radd runs 0x100..0x1CB, and 204 bytes are written.

Source files
------------

// File: rtl/sfifo_if_ntuner.sv
// sfifo_if_ntuner: round-robin mux of NCH tuner packet buffers into a USB slave FIFO.
// Build macro SFIFO_CHTAG_EN: replace byte 0 of each packet with 8'hB0 + channel.

module sfifo_if_ntuner #(
  parameter int          NCH       = 3,
  parameter int          PKT_LEN   = 188,
  parameter logic [1:0]  FIFO_ADDR = 2'b01
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flaga,
  input  logic               flagb,
  output logic [1:0]         fadd,
  output logic               sloe,
  output logic               slrd,
  output logic               slwr,
  output logic [7:0]         data_out,
  output logic               pktstart_o,
  output logic               pktend_o,
  output logic [11:0]        pid_idx,
  output logic               mrxdv,
  input  logic [NCH-1:0]     pkt_rdy,
  input  logic [NCH-1:0]     pkt_half,
  input  logic [12*NCH-1:0]  pkt_pid,
  output logic [NCH-1:0]     pkt_ack,
  output logic               db_radd_en,
  output logic [8:0]         db_radd,
  input  logic [8*NCH-1:0]   db_rdata
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [7:0] LAST_OFF = 8'(PKT_LEN - 1);

`ifdef SFIFO_CHTAG_EN
  localparam bit CHTAG = 1'b1;
`else
  localparam bit CHTAG = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    END
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] last_q, last_d;
  logic [CW-1:0] ch_q, ch_d;
  logic          half_q, half_d;
  logic [11:0]   pid_q, pid_d;
  logic [7:0]    off_q, off_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s1_first_q, s1_first_d;

  logic          gnt_vld;
  logic [CW-1:0] gnt_ch;
  logic          sel_half;
  logic [11:0]   sel_pid;
  int            idx;
  logic          rd_acc;
  logic          wr;
  logic [7:0]    rd_sel;
  logic          unused_flaga;

  assign unused_flaga = flaga;

  // Round-robin pick: nearest ready channel after the last grant wins
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_ch   = last_q;
    sel_half = 1'b0;
    sel_pid  = 12'h000;
    idx      = 0;
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NCH;
      if (pkt_rdy[idx]) begin
        gnt_vld  = 1'b1;
        gnt_ch   = CW'(idx);
        sel_half = pkt_half[idx];
        sel_pid  = pkt_pid[12*idx +: 12];
      end
    end
  end

  // Next state, read issue and stage-1 pipeline control
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    ch_d       = ch_q;
    half_d     = half_q;
    pid_d      = pid_q;
    off_d      = off_q;
    s1_vld_d   = s1_vld_q;
    s1_first_d = s1_first_q;
    rd_acc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = XFER;
          last_d  = gnt_ch;
          ch_d    = gnt_ch;
          half_d  = sel_half;
          pid_d   = sel_pid;
          off_d   = 8'h00;
        end
      end
      XFER: begin
        if (flagb) begin
          rd_acc = 1'b1;
          if (off_q == LAST_OFF) begin
            state_d = DRAIN;
          end else begin
            off_d = off_q + 8'h01;
          end
        end
      end
      DRAIN: begin
        if (s1_vld_q && flagb) begin
          state_d = END;
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A stalled FIFO freezes the pending byte along with the memory output
    if (flagb) begin
      s1_vld_d   = rd_acc;
      s1_first_d = rd_acc && (off_q == 8'h00);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= CW'(NCH - 1);
      ch_q       <= '0;
      half_q     <= 1'b0;
      pid_q      <= 12'h000;
      off_q      <= 8'h00;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ch_q       <= ch_d;
      half_q     <= half_d;
      pid_q      <= pid_d;
      off_q      <= off_d;
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
    end
  end

  // Granted channel's buffer byte, optionally tagged on byte 0
  always_comb begin
    rd_sel   = 8'h00;
    data_out = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == CW'(i)) begin
        rd_sel = db_rdata[8*i +: 8];
      end
    end
    if (s1_vld_q) begin
      data_out = rd_sel;
      if (CHTAG && s1_first_q) begin
        data_out = 8'hB0 + 8'(ch_q);
      end
    end
  end

  // Per-channel consume pulse in the END cycle
  always_comb begin
    pkt_ack = '0;
    for (int i = 0; i < NCH; i++) begin
      if (state_q == END && ch_q == CW'(i)) begin
        pkt_ack[i] = 1'b1;
      end
    end
  end

  assign wr         = s1_vld_q & flagb;
  assign slwr       = ~wr;
  assign pktstart_o = ~(wr & s1_first_q);
  assign pktend_o   = ~(state_q == END);
  assign mrxdv      = (state_q != IDLE);
  assign db_radd_en = (state_q == XFER) & flagb;
  assign db_radd    = {half_q, off_q};
  assign pid_idx    = pid_q;
  assign fadd       = FIFO_ADDR;
  assign sloe       = 1'b1;
  assign slrd       = 1'b1;

endmodule

// File: tb/tb_sfifo_if_ntuner.sv
// tb_sfifo_if_ntuner: directed bench for sfifo_if_ntuner.
// Main DUT NCH=3/PKT_LEN=188, second DUT NCH=1/PKT_LEN=204.

module tb_sfifo_if_ntuner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flaga, flagb;
  logic [1:0]  fadd;
  logic        sloe, slrd, slwr;
  logic [7:0]  data_out;
  logic        pktstart_o, pktend_o;
  logic [11:0] pid_idx;
  logic        mrxdv;
  logic [2:0]  pkt_rdy, pkt_half, pkt_ack;
  logic [35:0] pkt_pid;
  logic        db_radd_en;
  logic [8:0]  db_radd;
  logic [23:0] db_rdata = '0;

  logic [1:0]  fadd2;
  logic        sloe2, slrd2, slwr2;
  logic [7:0]  data_out2;
  logic        pktstart2, pktend2;
  logic [11:0] pid_idx2;
  logic        mrxdv2;
  logic [0:0]  pkt_rdy2, pkt_half2, pkt_ack2;
  logic [11:0] pkt_pid2;
  logic        db_radd_en2;
  logic [8:0]  db_radd2;
  logic [7:0]  db_rdata2 = '0;

  sfifo_if_ntuner #(.NCH(3), .PKT_LEN(188), .FIFO_ADDR(2'b01)) dut (
    .clk(clk), .rst(rst), .flaga(flaga), .flagb(flagb),
    .fadd(fadd), .sloe(sloe), .slrd(slrd), .slwr(slwr),
    .data_out(data_out), .pktstart_o(pktstart_o), .pktend_o(pktend_o),
    .pid_idx(pid_idx), .mrxdv(mrxdv), .pkt_rdy(pkt_rdy),
    .pkt_half(pkt_half), .pkt_pid(pkt_pid), .pkt_ack(pkt_ack),
    .db_radd_en(db_radd_en), .db_radd(db_radd), .db_rdata(db_rdata)
  );

  sfifo_if_ntuner #(.NCH(1), .PKT_LEN(204), .FIFO_ADDR(2'b01)) dut2 (
    .clk(clk), .rst(rst), .flaga(flaga), .flagb(flagb),
    .fadd(fadd2), .sloe(sloe2), .slrd(slrd2), .slwr(slwr2),
    .data_out(data_out2), .pktstart_o(pktstart2), .pktend_o(pktend2),
    .pid_idx(pid_idx2), .mrxdv(mrxdv2), .pkt_rdy(pkt_rdy2),
    .pkt_half(pkt_half2), .pkt_pid(pkt_pid2), .pkt_ack(pkt_ack2),
    .db_radd_en(db_radd_en2), .db_radd(db_radd2), .db_rdata(db_rdata2)
  );

  function automatic logic [7:0] mdat(int ch, int half, int off);
    if (off == 0) return 8'h47;
    return 8'(off * 3 + ch * 50 + half * 7 + 1);
  endfunction

  function automatic logic [7:0] exp_b0(int ch);
`ifdef SFIFO_CHTAG_EN
    return 8'(8'hB0 + ch);
`else
    return 8'h47;
`endif
  endfunction

  // Registered-read buffer models
  always @(posedge clk) begin
    if (db_radd_en)
      for (int c = 0; c < 3; c++)
        db_rdata[8*c +: 8] <= mdat(c, int'(db_radd[8]), int'(db_radd[7:0]));
    if (db_radd_en2)
      db_rdata2 <= mdat(0, int'(db_radd2[8]), int'(db_radd2[7:0]));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  wq[$];
  logic [2:0]  acks[$];
  logic [11:0] pids[$];
  int nstart, start_idx, last_wr_cyc, end_cyc, nend, stall_wr;
  int ack_cnt, bad_ack;
  logic [2:0]  end_ack;
  logic [11:0] end_pid;

  logic [7:0] wq2[$];
  int n2_end, n2_en, a2_seen, n2_ack_bad;
  logic [8:0] a2_first, a2_last;
  logic [11:0] pid2_end;

  always @(negedge clk) begin
    if (pkt_ack != 3'b000) ack_cnt++;
    if (rst) begin
      if (!slwr) begin
        if (!pktstart_o) begin
          start_idx = wq.size();
          nstart++;
        end
        wq.push_back(data_out);
        last_wr_cyc = cyc;
        if (!flagb) stall_wr++;
      end
      if (pkt_ack != 3'b000 && pktend_o) bad_ack++;
      if (!pktend_o) begin
        nend++;
        end_cyc = cyc;
        end_ack = pkt_ack;
        end_pid = pid_idx;
        acks.push_back(pkt_ack);
        pids.push_back(pid_idx);
      end
      if (!slwr2) wq2.push_back(data_out2);
      if (db_radd_en2) begin
        if (a2_seen == 0) a2_first = db_radd2;
        a2_seen = 1;
        a2_last = db_radd2;
        n2_en++;
      end
      if (!pktend2) begin
        n2_end++;
        pid2_end = pid_idx2;
        if (pkt_ack2 !== 1'b1) n2_ack_bad++;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq.delete();
    acks.delete();
    pids.delete();
    nstart = 0; start_idx = -1; nend = 0; stall_wr = 0;
    ack_cnt = 0; bad_ack = 0; end_ack = '0; end_pid = '0;
    last_wr_cyc = -10; end_cyc = -20;
  endtask

  task automatic wait_ends(input int n, output bit ok);
    for (int i = 0; i < 5000 && nend < n; i++) step();
    ok = (nend >= n);
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    for (int i = 0; i < 2000 && wq.size() < n; i++) step();
    ok = (wq.size() >= n);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    pkt_rdy = '0;
    flagb = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [38:0] got, want;
    rst = 1'b0;
    repeat (2) step();
    got  = {slwr, pktstart_o, pktend_o, pkt_ack, db_radd_en, db_radd,
            pid_idx, mrxdv, data_out};
    want = {1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 9'h000, 12'h000, 1'b0, 8'h00};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", got, want);
    end
    n_cmp++;
    if ({fadd, sloe, slrd} !== 4'b0111) begin
      n_bad++;
      $display("FAIL const_outputs: got %b want 0111", {fadd, sloe, slrd});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit ok;
    int bad;
    clear_mon();
    pkt_pid = {12'h302, 12'h201, 12'h100};
    pkt_half = 3'b000;
    pkt_rdy = 3'b001;
    wait_bytes(10, ok);
    n_cmp++;
    if (!ok || pid_idx !== 12'h100 || mrxdv !== 1'b1) begin
      n_bad++;
      $display("FAIL single_pid_mid: got %h/%b want 100/1", pid_idx, mrxdv);
    end
    pkt_pid[11:0] = 12'h3FF;
    pkt_half = 3'b111;
    pkt_rdy = 3'b110;
    step();
    pkt_rdy = 3'b001;
    pkt_half = 3'b000;
    wait_ends(1, ok);
    pkt_rdy = 3'b000;
    pkt_pid[11:0] = 12'h100;
    n_cmp++;
    if (!ok || wq.size() != 188) begin
      n_bad++;
      $display("FAIL single_count: got %0d want 188", wq.size());
    end
    bad = 0;
    for (int i = 0; i < wq.size() && i < 188; i++)
      if (wq[i] !== ((i == 0) ? exp_b0(0) : mdat(0, 0, i))) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL single_data: got %0d bad bytes want 0", bad);
    end
    n_cmp++;
    if (nstart != 1 || start_idx != 0) begin
      n_bad++;
      $display("FAIL single_start: got n=%0d idx=%0d want 1/0", nstart, start_idx);
    end
    n_cmp++;
    if (end_cyc != last_wr_cyc + 1) begin
      n_bad++;
      $display("FAIL single_end_timing: got %0d want %0d", end_cyc, last_wr_cyc + 1);
    end
    n_cmp++;
    if (end_ack !== 3'b001 || end_pid !== 12'h100 || bad_ack != 0) begin
      n_bad++;
      $display("FAIL single_ack: got %b/%h/%0d want 001/100/0", end_ack, end_pid, bad_ack);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [2:0] ack_want [4];
    logic [11:0] pid_want [4];
    ack_want = '{3'b001, 3'b010, 3'b100, 3'b001};
    pid_want = '{12'h100, 12'h201, 12'h302, 12'h100};
    apply_reset();
    clear_mon();
    pkt_pid = {12'h302, 12'h201, 12'h100};
    pkt_rdy = 3'b111;
    wait_ends(4, ok);
    pkt_rdy = 3'b000;
    n_cmp++;
    if (!ok || wq.size() != 4 * 188) begin
      n_bad++;
      $display("FAIL rr_count: got %0d want 752", wq.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (acks.size() <= i || acks[i] !== ack_want[i] || pids[i] !== pid_want[i]) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got %b/%h want %b/%h", i,
                 (acks.size() > i) ? acks[i] : 3'bxxx,
                 (pids.size() > i) ? pids[i] : 12'hxxx,
                 ack_want[i], pid_want[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int bad, held;
    apply_reset();
    clear_mon();
    pkt_rdy = 3'b010;
    wait_bytes(100, ok);
    flagb = 1'b0;
    repeat (5) step();
    held = wq.size();
    flagb = 1'b1;
    wait_ends(1, ok);
    pkt_rdy = 3'b000;
    n_cmp++;
    if (stall_wr != 0 || held != 100) begin
      n_bad++;
      $display("FAIL stall_hold: got wr=%0d held=%0d want 0/100", stall_wr, held);
    end
    bad = 0;
    for (int i = 0; i < wq.size() && i < 188; i++)
      if (wq[i] !== ((i == 0) ? exp_b0(1) : mdat(1, 0, i))) bad++;
    n_cmp++;
    if (!ok || wq.size() != 188 || bad != 0) begin
      n_bad++;
      $display("FAIL stall_data: got n=%0d bad=%0d want 188/0", wq.size(), bad);
    end
    n_cmp++;
    if (end_ack !== 3'b010) begin
      n_bad++;
      $display("FAIL stall_ack: got %b want 010", end_ack);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [38:0] got, want;
    apply_reset();
    clear_mon();
    pkt_rdy = 3'b100;
    wait_bytes(50, ok);
    rst = 1'b0;
    step();
    got  = {slwr, pktstart_o, pktend_o, pkt_ack, db_radd_en, db_radd,
            pid_idx, mrxdv, data_out};
    want = {1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 9'h000, 12'h000, 1'b0, 8'h00};
    n_cmp++;
    if (!ok || got !== want) begin
      n_bad++;
      $display("FAIL midrst_outputs: got %h want %h", got, want);
    end
    repeat (2) step();
    rst = 1'b1;
    pkt_rdy = 3'b111;
    step();
    n_cmp++;
    if (nend != 0 || ack_cnt != 0) begin
      n_bad++;
      $display("FAIL midrst_noack: got end=%0d ack=%0d want 0/0", nend, ack_cnt);
    end
    wait_ends(1, ok);
    pkt_rdy = 3'b000;
    n_cmp++;
    if (!ok || end_ack !== 3'b001) begin
      n_bad++;
      $display("FAIL midrst_regrant: got %b want 001", end_ack);
    end
  endtask

  task automatic test_chtag();
    bit ok;
    apply_reset();
    clear_mon();
    pkt_rdy = 3'b100;
    wait_ends(1, ok);
    pkt_rdy = 3'b000;
    n_cmp++;
    if (!ok || wq.size() < 2 || wq[0] !== exp_b0(2) || wq[1] !== mdat(2, 0, 1)) begin
      n_bad++;
      $display("FAIL chtag_byte0: got %h want %h",
               (wq.size() > 0) ? wq[0] : 8'hxx, exp_b0(2));
    end
    n_cmp++;
    if (end_ack !== 3'b100 || end_pid !== 12'h302) begin
      n_bad++;
      $display("FAIL chtag_ack: got %b/%h want 100/302", end_ack, end_pid);
    end
  endtask

  task automatic test_len204();
    int bad;
    int i;
    wq2.delete();
    n2_end = 0; n2_en = 0; a2_seen = 0; n2_ack_bad = 0;
    pkt_half2 = 1'b1;
    pkt_pid2 = 12'hABC;
    pkt_rdy2 = 1'b1;
    for (i = 0; i < 1000 && n2_end < 2; i++) step();
    pkt_rdy2 = 1'b0;
    n_cmp++;
    if (n2_end != 2 || wq2.size() != 408 || n2_en != 408) begin
      n_bad++;
      $display("FAIL len204_count: got end=%0d wr=%0d en=%0d want 2/408/408",
               n2_end, wq2.size(), n2_en);
    end
    n_cmp++;
    if (a2_first !== 9'h100 || a2_last !== 9'h1CB) begin
      n_bad++;
      $display("FAIL len204_addr: got %h..%h want 100..1cb", a2_first, a2_last);
    end
    bad = 0;
    for (int k = 0; k < wq2.size(); k++)
      if (wq2[k] !== (((k % 204) == 0) ? exp_b0(0) : mdat(0, 1, k % 204))) bad++;
    n_cmp++;
    if (bad != 0 || n2_ack_bad != 0 || pid2_end !== 12'hABC) begin
      n_bad++;
      $display("FAIL len204_data: got bad=%0d ackbad=%0d pid=%h want 0/0/abc",
               bad, n2_ack_bad, pid2_end);
    end
  endtask

  initial begin
    rst = 1'b0;
    flaga = 1'b1;
    flagb = 1'b1;
    pkt_rdy = '0;
    pkt_half = '0;
    pkt_pid = '0;
    pkt_rdy2 = '0;
    pkt_half2 = '0;
    pkt_pid2 = '0;
    clear_mon();
    wq2.delete();
    n2_end = 0; n2_en = 0; a2_seen = 0; n2_ack_bad = 0;
    a2_first = '0; a2_last = '0; pid2_end = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_chtag();
    test_len204();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
